// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/response channel between fetch unit and memory
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with a 2-entry {pc, instr} queue and redirect draining
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  instr_fetch_unit_if.master        bus,
  output logic                      EN_PC_O,
  output logic [31:0]               PC_O,
  output logic [31:0]               instr_O,
  output logic                      flush_O
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, r_req_pc;
  logic        r_out, w_out_nxt;
  logic [31:0] r_pc [2];
  logic [31:0] r_ins [2];
  logic        r_head;
  logic [1:0]  r_cnt;
  logic        w_run, w_fire, w_push, w_pop;
  assign w_run         = r_state == RUN;
  // one request in flight at most, so a new request waits for the previous response
  assign bus.imem_req  = rst_n && w_run && !redirect && !r_out && !r_cnt[1];
  assign bus.imem_addr = {r_fetch_pc[29:0], 2'b00};
  assign w_fire        = bus.imem_req && bus.imem_gnt;
  assign w_push        = w_run && r_out && bus.imem_rvalid && !redirect;
  assign EN_PC_O       = rst_n && r_cnt != 2'd0;
  assign w_pop         = EN_PC_O && !stall && !redirect;
  assign PC_O          = EN_PC_O ? r_pc[r_head] : '0;
  assign instr_O       = EN_PC_O ? r_ins[r_head] : '0;
  assign flush_O       = redirect;
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    if (!w_run) begin
      w_out_nxt   = !bus.imem_rvalid;
      w_state_nxt = bus.imem_rvalid ? RUN : DRAIN;
    end else if (redirect) begin
      w_out_nxt   = r_out && !bus.imem_rvalid;
      w_state_nxt = (r_out && !bus.imem_rvalid) ? DRAIN : RUN;
    end else begin
      w_out_nxt = w_fire ? 1'b1 : (bus.imem_rvalid ? 1'b0 : r_out);
    end
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_out      <= 1'b0;
      r_cnt      <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_cnt      <= 2'd0;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd1;
          r_req_pc   <= r_fetch_pc;
        end
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        if (w_pop) r_head <= !r_head;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pc[r_head ^ r_cnt[0]]  <= r_req_pc;
      r_ins[r_head ^ r_cnt[0]] <= bus.imem_rdata;
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0, word-index PC loaded at reset.
REQ-002 SHALL have port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: stall  in  1  downstream IF/ID register holding; no pop.
REQ-005 SHALL have ports: redirect  in  1  and redirect_pc  in  32  taken branch/jump, word-index target.
REQ-006 SHALL have ports: imem_req  out  1,  imem_addr  out  32 (byte address),  imem_gnt  in  1  request accepted.
REQ-007 SHALL have ports: imem_rvalid  in  1,  imem_rdata  in  32  response, in order, at least 1 cycle after gnt.
REQ-008 SHALL have ports: EN_PC_O  out  1  output valid,  PC_O  out  32  word-index PC,  instr_O  out  32.
REQ-009 SHALL have port: flush_O  out  1  flush to IF/ID register.

Function
REQ-010 SHALL keep fetch_pc (word index); imem_addr = {fetch_pc[29:0], 2'b00}.
REQ-011 SHALL hold a 2-entry FIFO of {pc, instr}, plus an outstanding flag (max 1 in flight).
REQ-012 SHALL use states RUN and DRAIN; DRAIN = one in-flight response to be discarded.
REQ-013 SHALL assert imem_req only in RUN, redirect=0, and (occupancy + outstanding) < 2.
REQ-014 SHALL keep imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-015 SHALL, on imem_req && imem_gnt: set outstanding, record the request PC, fetch_pc <= fetch_pc + 1, mod 2^32.
REQ-016 SHALL, on imem_rvalid in RUN with outstanding: push {request PC, imem_rdata}; clear outstanding.
REQ-017 SHALL ignore imem_rvalid when outstanding=0.
REQ-018 SHALL drive EN_PC_O = FIFO non-empty; PC_O/instr_O = head entry, zero when empty.
REQ-019 SHALL pop the head when EN_PC_O && !stall; push and pop in the same cycle both take effect.
REQ-020 SHALL never push into a full FIFO, guaranteed by REQ-013; bench asserts this.
REQ-021 SHALL drive flush_O = redirect combinationally, same cycle.
REQ-022 SHALL, on redirect: fetch_pc <= redirect_pc; FIFO emptied; imem_req forced 0 that cycle, so a gnt in that cycle is ignored.
REQ-023 SHALL, on redirect with outstanding=1 and no rvalid that cycle: enter DRAIN.
REQ-024 SHALL, on redirect coinciding with rvalid: drop that response, clear outstanding, stay or return to RUN.
REQ-025 SHALL, in DRAIN: issue no request; on rvalid, discard data, clear outstanding, go to RUN.
REQ-026 SHALL, on redirect while in DRAIN: update fetch_pc only and stay in DRAIN.
REQ-027 SHALL give redirect priority over stall, push and pop.
REQ-028 SHALL have a latency of 1 cycle from rvalid to EN_PC_O with FIFO empty; with 1-cycle memory, throughput is 1 instr per 2 cycles.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge: fetch_pc=RESET_PC, FIFO empty, outstanding=0, state RUN.
REQ-030 SHALL hold outputs 0 during and after reset: EN_PC_O=0, PC_O=0, instr_O=0, imem_req=0 while rst_n=0, flush_O follows redirect.
REQ-031 SHALL treat reset mid-operation as abandoning all in-flight state; memory shares rst_n, so no stale rvalid arrives.
REQ-032 SHALL assert imem_req with imem_addr=RESET_PC*4 on the first cycle after rst_n rises.

Verification
REQ-033 Scenario: reset, RESET_PC=0, gnt=1, 1-cycle rvalid -> imem_addr sequence 0,4,8; EN_PC_O outputs PC_O=0,1,2 with matching rdata.
REQ-034 Scenario: stall=1 for 4 cycles -> FIFO fills to 2, imem_req=0, PC_O constant; release -> in-order drain, no loss or duplicate.
REQ-035 Scenario: redirect, redirect_pc=0x40, while outstanding -> flush_O=1 that cycle, DRAIN; next rvalid discarded; next imem_addr=0x100.
REQ-036 Scenario: redirect coincident with rvalid and gnt -> response dropped, gnt ignored, next request addr=redirect_pc*4, state RUN.
REQ-037 Scenario: gnt held 0 for 3 cycles -> imem_addr unchanged and fetch_pc unchanged until gnt.
REQ-038 Scenario: rst_n=0 for 1 cycle with FIFO full and outstanding -> EN_PC_O=0 next cycle; fetch restarts at RESET_PC.
